// File: rtl/encoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_pkg: shared state encoding and width helper for encoder blocks    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package encoder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Index width that never collapses to zero for tiny N.
    function automatic int clog2_safe(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_scan_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_scan_n_if: request-word input and index-beat output handshakes    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface encoder_scan_n_if
    import encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_safe(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_word;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_zero;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/encoder_scan_n_prio_idx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prio_idx_n: combinational find-first-set with one-hot mask and single flag|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module prio_idx_n
    import encoder_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int W         = clog2_safe(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o,
    output logic         single_o
);

    // The last matching iteration wins, so scan direction picks the priority end.
    generate
        if (MSB_FIRST) begin : g_msb
            always_comb begin
                idx_o = '0;
                for (int i = 0; i < N; i++) begin
                    if (vec_i[i]) idx_o = W'(i);
                end
            end
        end else begin : g_lsb
            always_comb begin
                idx_o = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (vec_i[i]) idx_o = W'(i);
                end
            end
        end
    endgenerate

    assign onehot_o = (|vec_i) ? (N'(1) << idx_o) : '0;
    assign single_o = (|vec_i) & ~(|(vec_i & (vec_i - N'(1))));

endmodule
`default_nettype wire

// File: rtl/encoder_scan_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_scan_n: emits the index of every set bit of a word, one per beat  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module encoder_scan_n
    import encoder_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit ZERO_RPT  = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    encoder_scan_n_if.slave    bus
);

    localparam int W = clog2_safe(N);

    state_t       state_q, state_d;
    logic [N-1:0] pend_q,  pend_d;
    logic         zero_q,  zero_d;

    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_mask;
    logic         sel_single;
    logic         out_valid;
    logic         out_last;
    logic         hs;
    logic         accept;

    prio_idx_n #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST),
        .W         (W)
    ) u_prio (
        .vec_i    (pend_q),
        .idx_o    (sel_idx),
        .onehot_o (sel_mask),
        .single_o (sel_single)
    );

    assign out_valid = (state_q == ST_SCAN);
    assign out_last  = out_valid & (sel_single | zero_q);
    assign hs        = out_valid & bus.out_ready;
    assign accept    = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid;
    assign bus.out_idx   = sel_idx;
    assign bus.out_last  = out_last;
    assign bus.out_zero  = out_valid & zero_q;
    assign bus.in_ready  = ~rst & ((state_q == ST_IDLE) | (hs & out_last));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zero_d  = zero_q;
        if (hs) begin
            pend_d = pend_q & ~sel_mask;
            if (out_last) begin
                state_d = ST_IDLE;
                zero_d  = 1'b0;
            end
        end
        // A new word overrides the retiring one when both happen in one cycle.
        if (accept) begin
            if (|bus.in_word) begin
                pend_d  = bus.in_word;
                zero_d  = 1'b0;
                state_d = ST_SCAN;
            end else if (ZERO_RPT) begin
                pend_d  = '0;
                zero_d  = 1'b1;
                state_d = ST_SCAN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encoder_scan_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_encoder_scan_n: directed scoreboard bench for encoder_scan_n           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_encoder_scan_n;
    import encoder_pkg::*;

    localparam int N = 8;
    localparam int W = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Beat encoding: {zero, last, idx}
    bit [W+1:0] qa[$];
    bit [W+1:0] qb[$];
    bit [W+1:0] qc[$];

    encoder_scan_n_if #(.N(N), .W(W)) ifa ();
    encoder_scan_n_if #(.N(N), .W(W)) ifb ();
    encoder_scan_n_if #(.N(N), .W(W)) ifc ();

    encoder_scan_n #(.N(N), .MSB_FIRST(1'b0), .ZERO_RPT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    encoder_scan_n #(.N(N), .MSB_FIRST(1'b1), .ZERO_RPT(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    encoder_scan_n #(.N(N), .MSB_FIRST(1'b0), .ZERO_RPT(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: beats a word should produce, appended to the chosen queue.
    task automatic push_exp(input int which, input logic [N-1:0] w, input bit msb, input bit zr);
        bit [W+1:0] beats[$];
        int cnt;
        int n;
        int i;
        cnt = $countones(w);
        n   = 0;
        if (w == '0) begin
            if (zr) beats.push_back({1'b1, 1'b1, 3'd0});
        end else begin
            for (int k = 0; k < N; k++) begin
                i = msb ? (N - 1 - k) : k;
                if (w[i]) begin
                    n++;
                    beats.push_back({1'b0, (n == cnt), i[W-1:0]});
                end
            end
        end
        foreach (beats[j]) begin
            if (which == 0)      qa.push_back(beats[j]);
            else if (which == 1) qb.push_back(beats[j]);
            else                 qc.push_back(beats[j]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", ifa.out_valid, 0);
            else chk("a_beat", {ifa.out_zero, ifa.out_last, ifa.out_idx}, qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", ifb.out_valid, 0);
            else chk("b_beat", {ifb.out_zero, ifb.out_last, ifb.out_idx}, qb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (qc.size() == 0) chk("c_unexpected_beat", ifc.out_valid, 0);
            else chk("c_beat", {ifc.out_zero, ifc.out_last, ifc.out_idx}, qc.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_word = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_word = '0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_word = '0; ifc.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready",  ifa.in_ready,  0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_idx",   ifa.out_idx,   0);
        chk("rst_out_last",  ifa.out_last,  0);
        chk("rst_out_zero",  ifa.out_zero,  0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", ifa.in_ready, 1);

        // 1: LSB-first scan of 1001_0100, one beat per cycle
        ifa.in_valid = 1'b1; ifa.in_word = 8'b1001_0100;
        push_exp(0, 8'b1001_0100, 1'b0, 1'b1);
        tick();
        ifa.in_valid = 1'b0;
        chk("t1_lat_valid", ifa.out_valid, 1);
        tick();
        chk("t1_beat2_valid", ifa.out_valid, 1);
        tick();
        chk("t1_beat3_last", {ifa.out_valid, ifa.out_last}, 2'b11);
        tick();
        chk("t1_done_valid", ifa.out_valid, 0);
        chk("t1_done_ready", ifa.in_ready, 1);

        // 2: MSB-first, followed by a one-hot word accepted on the last beat
        ifb.in_valid = 1'b1; ifb.in_word = 8'b1001_0100;
        push_exp(1, 8'b1001_0100, 1'b1, 1'b1);
        tick();
        ifb.in_word = 8'b0100_0000;
        push_exp(1, 8'b0100_0000, 1'b1, 1'b1);
        k = 0;
        while (!ifb.in_ready && k < 10) begin
            tick();
            k++;
        end
        chk("t2_accept_timeout", (k < 10), 1);
        tick();
        ifb.in_valid = 1'b0;
        chk("t2_onehot_beat", {ifb.out_valid, ifb.out_last, ifb.out_idx}, {2'b11, 3'd6});
        tick();
        chk("t2_done_valid", ifb.out_valid, 0);

        // 3: stall holds outputs stable
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_word = 8'b0000_0011;
        push_exp(0, 8'b0000_0011, 1'b0, 1'b1);
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_word  = 8'b1111_1111;
        for (int s = 0; s < 3; s++) begin
            chk("t3_stall_hold", {ifa.out_valid, ifa.out_last, ifa.out_idx}, {2'b10, 3'd0});
            tick();
        end
        ifa.out_ready = 1'b1;
        tick();
        chk("t3_second_beat", {ifa.out_valid, ifa.out_last, ifa.out_idx}, {2'b11, 3'd1});
        tick();
        chk("t3_done_valid", ifa.out_valid, 0);

        // 4: zero word reported on a, dropped on c
        ifa.in_valid = 1'b1; ifa.in_word = '0;
        push_exp(0, 8'h00, 1'b0, 1'b1);
        ifc.in_valid = 1'b1; ifc.in_word = '0;
        push_exp(2, 8'h00, 1'b0, 1'b0);
        tick();
        ifa.in_valid = 1'b0;
        ifc.in_valid = 1'b0;
        chk("t4_zero_flag", {ifa.out_valid, ifa.out_zero, ifa.out_last}, 3'b111);
        chk("t4_drop_valid", ifc.out_valid, 0);
        chk("t4_drop_ready", ifc.in_ready, 1);
        tick();
        chk("t4_zero_done", ifa.out_valid, 0);
        chk("t4_drop_still", ifc.out_valid, 0);
        ifc.in_valid = 1'b1; ifc.in_word = 8'b1000_0001;
        push_exp(2, 8'b1000_0001, 1'b0, 1'b0);
        tick();
        ifc.in_valid = 1'b0;
        tick();
        tick();
        chk("t4_c_done", ifc.out_valid, 0);

        // 5: new word accepted during the final beat, no bubble
        ifa.in_valid = 1'b1; ifa.in_word = 8'b1000_0000;
        push_exp(0, 8'b1000_0000, 1'b0, 1'b1);
        tick();
        chk("t5_last_ready", ifa.in_ready, 1);
        ifa.in_word = 8'b0000_0001;
        push_exp(0, 8'b0000_0001, 1'b0, 1'b1);
        tick();
        ifa.in_valid = 1'b0;
        chk("t5_no_bubble", {ifa.out_valid, ifa.out_last, ifa.out_idx}, {2'b11, 3'd0});
        tick();
        chk("t5_done_valid", ifa.out_valid, 0);

        // 6: reset mid-scan discards the remaining bits
        ifa.in_valid = 1'b1; ifa.in_word = 8'b1111_0000;
        qa.push_back({1'b0, 1'b0, 3'd4});
        tick();
        ifa.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", ifa.in_ready, 0);
        tick();
        chk("t6_rst_out_valid", ifa.out_valid, 0);
        rst = 1'b0;
        #1;
        chk("t6_post_rst_ready", ifa.in_ready, 1);
        for (int s = 0; s < 4; s++) tick();
        chk("t6_no_more_beats", ifa.out_valid, 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
